// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
// Shared definitions for the flop-chain sequencer:
//   state_t / IDLE / RUN / DONE : 2-bit controller state encoding
//   DEF_WIDTH / DEF_DEPTH       : default word width and chain depth
//   DEF_LAST_CNT                : last run count for the default sizes
//   cnt_width()                 : width of the run counter
//   last_cnt()                  : count value at which a run completes
package shift_seq_pkg;

  // The state type is a plain 2-bit vector.
  // The named constants keep legacy tools that dislike enums happy.
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 2;
  localparam int DEF_LAST_CNT = DEF_WIDTH + DEF_DEPTH - 1;

  // The counter must reach WIDTH+DEPTH-1 and still be able to form cnt+1
  // for the serializer look-ahead without wrapping.
  function automatic int cnt_width(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

  // The run ends on the edge where the last deserialized bit arrives.
  function automatic int last_cnt(input int width, input int depth);
    return width + depth - 1;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// shift_seq_cnt
// Run counter for the sequencer.
//   clk   in  : rising-edge clock
//   rst_n in  : asynchronous active-low reset
//   clear in  : synchronous clear to zero (has priority over en)
//   en    in  : increment by one
//   cnt   out : current count
//   tc    out : high while cnt equals LAST
module shift_seq_cnt #(
  parameter int CW   = 4,
  parameter int LAST = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  // Clear wins over enable.
  // A run accepted straight out of DONE restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal count is decoded combinationally.
  // The controller can act on the same edge that samples the last bit.
  assign tc = (cnt == CW'(LAST));

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Serializes a parallel word onto an external flop chain, LSB first.
// Collects the chain output back into a word after DEPTH cycles of latency.
// Flags any difference between the sent word and the returned word.
//   clk      in  : rising-edge clock
//   rst_n    in  : asynchronous active-low reset
//   start    in  : run request, honoured in IDLE and DONE only
//   din      in  : word to send, latched when start is accepted
//   d_out    out : registered serial bit to the chain d input
//   q_in     in  : serial bit from the chain's last stage
//   busy     out : high while a run is in progress
//   done     out : one-cycle pulse when the run completes
//   dout     out : returned word, valid from done until the next start
//   mismatch out : dout differs from the sent word, updated with done
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             d_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             mismatch
);

  localparam int CW   = cnt_width(WIDTH, DEPTH);
  localparam int LAST = last_cnt(WIDTH, DEPTH);
  localparam int IW   = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             run_en;
  logic [CW-1:0]    cnt_nxt;
  logic [IW-1:0]    cap_idx;
  logic             d_next;
  logic [WIDTH-1:0] dout_next;

  // A new run can begin from IDLE or straight out of DONE.
  // This gives back-to-back runs with no gap.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign run_en = (state == RUN);
  assign busy   = (state == RUN);

  shift_seq_cnt #(
    .CW   (CW),
    .LAST (LAST)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (run_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  // The serializer looks one bit ahead, because d_out is registered.
  // After the word is exhausted, zeros are fed while the chain drains.
  // The deserializer lags the count by DEPTH.
  // The bit seen at count c belongs to position c-DEPTH.
  // dout_next already includes the bit landing this edge.
  // That lets mismatch be judged on the completed word.
  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    cap_idx   = IW'(cnt - CW'(DEPTH));
    d_next    = 1'b0;
    dout_next = dout;
    if (cnt_nxt < CW'(WIDTH)) begin
      d_next = word[IW'(cnt_nxt)];
    end
    if (cnt >= CW'(DEPTH)) begin
      dout_next[cap_idx] = q_in;
    end
  end

  // Main controller.
  // IDLE and DONE behave identically towards start.
  // DONE differs only in lasting a single cycle and carrying the done pulse.
  // done defaults low each edge, so it is a one-cycle pulse.
  // dout and mismatch hold their values until the next run overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= '0;
      d_out    <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            word  <= din;
            d_out <= din[0];
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          d_out <= d_next;
          dout  <= dout_next;
          if (tc) begin
            mismatch <= (dout_next != word);
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl with a scoreboard.
// dut2 (DEPTH=2) drives a selectable 2-stage or 1-stage chain.
// dut1 (DEPTH=1) drives a 1-stage chain.
// Expected results are queued when a run is started.
// A monitor per DUT pops and compares them on each done pulse.
module tb_shift_seq_ctrl;

  typedef struct {
    logic [7:0] dout;
    logic       mm;
    int         done_cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       short_chain;
  int         cyc;
  int         n_checks;
  int         n_fail;
  exp_t       sb2[$];
  exp_t       sb1[$];

  logic       start2, d_out2, q_in2, busy2, done2, mismatch2;
  logic [7:0] din2, dout2;
  logic       start1, d_out1, q_in1, busy1, done1, mismatch1;
  logic [7:0] din1, dout1;
  logic       s1a, s2a, c1;

  shift_seq_ctrl #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .din      (din2),
    .d_out    (d_out2),
    .q_in     (q_in2),
    .busy     (busy2),
    .done     (done2),
    .dout     (dout2),
    .mismatch (mismatch2)
  );

  shift_seq_ctrl #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .din      (din1),
    .d_out    (d_out1),
    .q_in     (q_in1),
    .busy     (busy1),
    .done     (done1),
    .dout     (dout1),
    .mismatch (mismatch1)
  );

  // External flop chains built from nonblocking stages.
  // short_chain models the blocking-collapsed version, which loses one stage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1a <= 1'b0;
      s2a <= 1'b0;
      c1  <= 1'b0;
    end else begin
      s1a <= d_out2;
      s2a <= s1a;
      c1  <= d_out1;
    end
  end

  assign q_in2 = short_chain ? s1a : s2a;
  assign q_in1 = c1;

  always #5 clk = ~clk;

  // Count rising edges.
  // At a negedge, cyc equals the index of the edge just passed.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Raise start at a negedge and queue the expected result.
  // Start is accepted at the next edge (cyc+1).
  // done shows after edge cyc+1+WIDTH+DEPTH.
  // Returns one cycle later with start dropped.
  task automatic applyStimulus(input int sel, input logic [7:0] word,
                               input logic [7:0] exp_dout, input logic exp_mm);
    exp_t e;
    e.dout = exp_dout;
    e.mm   = exp_mm;
    if (sel == 1) begin
      e.done_cyc = cyc + 1 + 9;
      sb1.push_back(e);
      din1   = word;
      start1 = 1'b1;
    end else begin
      e.done_cyc = cyc + 1 + 10;
      sb2.push_back(e);
      din2   = word;
      start2 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb2.size() != 0 || sb1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending expectations", 32'(sb2.size() + sb1.size()), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor for dut2.
  always @(negedge clk) begin
    if (done2) begin
      if (sb2.size() == 0) begin
        checkOutput("dut2 spurious done", {31'b0, done2}, 0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        checkOutput("dut2 dout", {24'b0, dout2}, {24'b0, e.dout});
        checkOutput("dut2 mismatch", {31'b0, mismatch2}, {31'b0, e.mm});
        checkOutput("dut2 done cycle", cyc, e.done_cyc);
        checkOutput("dut2 busy at done", {31'b0, busy2}, 0);
      end
    end
  end

  // Scoreboard monitor for dut1.
  always @(negedge clk) begin
    if (done1) begin
      if (sb1.size() == 0) begin
        checkOutput("dut1 spurious done", {31'b0, done1}, 0);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        checkOutput("dut1 dout", {24'b0, dout1}, {24'b0, e.dout});
        checkOutput("dut1 mismatch", {31'b0, mismatch1}, {31'b0, e.mm});
        checkOutput("dut1 done cycle", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    logic [9:0] seq;
    clk         = 1'b0;
    cyc         = 0;
    n_checks    = 0;
    n_fail      = 0;
    short_chain = 1'b0;
    rst_n       = 1'b0;
    start2      = 1'b1;
    din2        = 8'hA5;
    start1      = 1'b1;
    din1        = 8'h01;

    // Reset held with start high: nothing may move.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset outputs dut2", {20'b0, busy2, done2, d_out2, mismatch2, dout2}, 0);
      checkOutput("reset outputs dut1", {20'b0, busy1, done1, d_out1, mismatch1, dout1}, 0);
    end
    start2 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset busy", {31'b0, busy2}, 0);

    // Matched 2-stage chain: check the serial stream and busy every cycle.
    $display("[TB] DEPTH=2, 2-stage chain, din=A5");
    applyStimulus(2, 8'hA5, 8'hA5, 1'b0);
    seq = {2'b00, 8'hA5};
    for (int j = 0; j < 10; j++) begin
      checkOutput($sformatf("d_out bit %0d", j), {31'b0, d_out2}, {31'b0, seq[j]});
      checkOutput($sformatf("busy cycle %0d", j), {31'b0, busy2}, 1);
      @(negedge clk);
    end
    checkOutput("busy after run", {31'b0, busy2}, 0);
    checkOutput("done after run", {31'b0, done2}, 1);
    drain();

    // One stage short: dout comes back shifted down by one.
    $display("[TB] DEPTH=2, 1-stage chain, din=A5");
    short_chain = 1'b1;
    applyStimulus(2, 8'hA5, 8'h52, 1'b1);
    drain();
    short_chain = 1'b0;
    @(negedge clk);

    // Back-to-back: start held high, second run taken in the done cycle.
    $display("[TB] back-to-back 3C then FF");
    begin
      exp_t e;
      e.dout = 8'h3C; e.mm = 1'b0; e.done_cyc = cyc + 11;
      sb2.push_back(e);
      e.dout = 8'hFF; e.mm = 1'b0; e.done_cyc = cyc + 22;
      sb2.push_back(e);
    end
    start2 = 1'b1;
    din2   = 8'h3C;
    @(negedge clk);
    din2 = 8'hFF;
    repeat (11) @(negedge clk);
    start2 = 1'b0;
    drain();

    // Start while running is ignored; a reset mid-run kills the run.
    $display("[TB] mid-run start and reset");
    start2 = 1'b1;
    din2   = 8'h5A;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkOutput("busy through ignored start", {31'b0, busy2}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset outputs", {20'b0, busy2, done2, d_out2, mismatch2, dout2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2, 8'h81, 8'h81, 1'b0);
    drain();

    // DEPTH=1 instance with a matching 1-stage chain.
    $display("[TB] DEPTH=1, 1-stage chain, din=01");
    applyStimulus(1, 8'h01, 8'h01, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer that drives a flip-flop chain (a D-flop pipeline built from the team's `block`/`nonblock` style cells) from a parallel word. It serializes the word onto the chain's `d` input LSB first and waits out the chain latency. It deserializes the chain's `q` output back into a word and flags any mismatch. It sits between the practice testbenches and the flop-chain datapath, giving a start/busy/done handshake in place of hand-timed `#` stimulus.

## Interface
- WIDTH, 8: bits per word; WIDTH ≥ 2.
- DEPTH, 2: flop stages in the attached chain (expected latency); DEPTH ≥ 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled in IDLE and DONE only.
- din  in  WIDTH  word to send; latched on accepted start.
- d_out  out  1  serial bit to chain `d` (registered).
- q_in  in  1  serial bit from chain `q` (last stage).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, run complete.
- dout  out  WIDTH  captured word; valid from done, held until next accepted start.
- mismatch  out  1  dout ≠ latched din; updated with done, held.

## Operation
- Reset (rst_n low, any time, including mid-run): state IDLE, d_out 0, busy 0, done 0, dout 0, mismatch 0, cnt 0, word register 0. The run in progress is discarded.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge e0 → latch din to word, d_out ← din[0], cnt ← 0, RUN. start=0 → stay.
- RUN: each edge, cnt ← cnt+1.
  - Next d_out = word[cnt+1] if cnt+1 < WIDTH, else 0.
  - If cnt ≥ DEPTH, dout[cnt−DEPTH] ← q_in.
  - At the edge where cnt = WIDTH+DEPTH−1: capture the last bit, compute mismatch, set done ← 1, go to DONE.
- start during RUN is ignored (no queueing).
- DONE: lasts one cycle, with done=1 and busy=0.
  - start=1 → accepted exactly as in IDLE (back-to-back run), done falls.
  - start=0 → IDLE.
- cnt width = clog2(WIDTH+DEPTH+1).
- Bits of dout not yet captured keep their previous-run values until overwritten; only the value at done is defined.

## Timing
- After edge e0+j (0 ≤ j < WIDTH): d_out = din[j]. For WIDTH ≤ j < WIDTH+DEPTH: d_out = 0.
- Chain contract: last-stage q shows bit j after edge e0+j+DEPTH. The controller samples it at edge e0+j+DEPTH+1.
- done is high in the cycle after edge e0+WIDTH+DEPTH. Run latency is WIDTH+DEPTH+1 cycles, start edge to done edge inclusive.
- busy is high for exactly WIDTH+DEPTH cycles.
- Back-to-back runs: period of WIDTH+DEPTH+1 cycles, with no idle cycle.
- If the chain latency ≠ DEPTH, dout is shifted, which is the intended detector. With a 1-stage chain at DEPTH=2: dout[j] = din[j+1], MSB = 0, mismatch = 1.

## Structure
- Package shift_seq_pkg holds:
  - the state typedef (IDLE/RUN/DONE, 2-bit encoding);
  - the counter-width function;
  - the localparam for last count (WIDTH+DEPTH−1).
- One natural sub-module: shift_seq_cnt, a parameterized run counter with clear/enable and a terminal-count output. The FSM, the serializer mux and the deserializer stay in the top.
- The flop chain is external and not instantiated here. The bench wires d_out → chain → q_in.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, no run starts until rst_n=1.
- DEPTH=2, 2-stage nonblocking chain, din=8'hA5 → d_out sequence 1,0,1,0,0,1,0,1,0,0; busy for 10 cycles; done in cycle 11; dout=8'hA5, mismatch=0.
- DEPTH=2, 1-stage (blocking-collapsed) chain, din=8'hA5 → dout=8'h52, mismatch=1.
- Back-to-back:
  - DEPTH=2, 2-stage chain: din=8'h3C, start held high → second run (din=8'hFF) accepted in the done cycle.
  - Required response: dout=8'h3C at first done, 8'hFF at second done; done pulses 11 cycles apart.
- Mid-run reset and ignored start:
  - start at cycle 0, start=1 again at cycle 4 → ignored.
  - rst_n=0 at cycle 6 → immediate IDLE, all outputs 0, no done.
  - New start after release with din=8'h81 → dout=8'h81.
- DEPTH=1, 1-stage chain, din=8'h01 → done 10 cycles after start edge, dout=8'h01, mismatch=0.
